dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Byte-addressed data memory with fixed-latency request/response
//            handshake, little-endian lanes and load sign/zero extension.
//            Optional macro DMEM_MISALIGN_CHECK_EN flags misaligned accesses
//            instead of silently aligning them.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int WAIT_CYCLES = 1,
    parameter int DEPTH_BYTES = 256
) (
    input  logic                     clk,
    input  logic                     CLR,
    input  logic                     req,
    input  logic                     we,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    input  logic                     Byte,
    input  logic                     Half,
    input  logic                     UnsignedExt_Mem,
    output logic                     ack,
    output logic [31:0]              rdata,
    output logic                     err,
    output logic                     busy,
    output logic [DEPTH_BYTES*8-1:0] ram_content
);

    localparam int c_AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic [1:0] c_SZ_BYTE = 2'd0;
    localparam logic [1:0] c_SZ_HALF = 2'd1;
    localparam logic [1:0] c_SZ_WORD = 2'd2;

    localparam logic [3:0] c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [c_AW-1:0] c_OFS1 = 1;
    localparam logic [c_AW-1:0] c_OFS2 = 2;
    localparam logic [c_AW-1:0] c_OFS3 = 3;

    logic [1:0]      r_state;
    logic [3:0]      r_cnt;
    logic            r_we;
    logic [c_AW-1:0] r_addr;
    logic [31:0]     r_wdata;
    logic [1:0]      r_size;
    logic            r_ext;
    logic            r_misalign;
    logic            r_ack;
    logic            r_err;
    logic            r_busy;
    logic [31:0]     r_rdata;
    logic [7:0]      r_mem [DEPTH_BYTES];

    logic [1:0]      w_size;
    logic            w_misalign;
    logic [c_AW-1:0] w_base;
    logic            w_from_idle;
    logic [c_AW-1:0] w_acc_addr;
    logic [1:0]      w_acc_size;
    logic            w_acc_ext;
    logic            w_acc_we;
    logic            w_acc_mis;
    logic [7:0]      w_b0;
    logic [7:0]      w_b1;
    logic [7:0]      w_b2;
    logic [7:0]      w_b3;
    logic [31:0]     w_load;
    logic [31:0]     w_rdata_next;
    logic            w_unused;

    // Address bits above the array size are deliberately discarded (wrap).
    assign w_unused = &{1'b0, addr[31:c_AW]};

    always_comb begin
        w_size = c_SZ_WORD;
        if (Byte) begin
            w_size = c_SZ_BYTE;
        end else if (Half) begin
            w_size = c_SZ_HALF;
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    assign w_misalign = ((w_size == c_SZ_HALF) && addr[0]) ||
                        ((w_size == c_SZ_WORD) && (addr[1:0] != 2'b00));
    assign w_base     = addr[c_AW-1:0];
`else
    assign w_misalign = 1'b0;
    always_comb begin
        w_base = addr[c_AW-1:0];
        if (w_size == c_SZ_HALF) begin
            w_base[0] = 1'b0;
        end else if (w_size == c_SZ_WORD) begin
            w_base[1:0] = 2'b00;
        end
    end
`endif

    // With zero wait cycles the response is formed on the capture edge, so the
    // load path must look at the live inputs rather than the capture registers.
    assign w_from_idle = (r_state == c_IDLE);
    assign w_acc_addr  = w_from_idle ? w_base     : r_addr;
    assign w_acc_size  = w_from_idle ? w_size     : r_size;
    assign w_acc_ext   = w_from_idle ? UnsignedExt_Mem : r_ext;
    assign w_acc_we    = w_from_idle ? we         : r_we;
    assign w_acc_mis   = w_from_idle ? w_misalign : r_misalign;

    assign w_b0 = r_mem[w_acc_addr];
    assign w_b1 = r_mem[w_acc_addr + c_OFS1];
    assign w_b2 = r_mem[w_acc_addr + c_OFS2];
    assign w_b3 = r_mem[w_acc_addr + c_OFS3];

    always_comb begin
        w_load = {w_b3, w_b2, w_b1, w_b0};
        case (w_acc_size)
            c_SZ_BYTE: w_load = w_acc_ext ? {24'd0, w_b0} : {{24{w_b0[7]}}, w_b0};
            c_SZ_HALF: w_load = w_acc_ext ? {16'd0, w_b1, w_b0} : {{16{w_b1[7]}}, w_b1, w_b0};
            default:   w_load = {w_b3, w_b2, w_b1, w_b0};
        endcase
        w_rdata_next = (w_acc_we || w_acc_mis) ? 32'd0 : w_load;
    end

    always_ff @(posedge clk or negedge CLR) begin
        if (!CLR) begin
            r_state    <= c_IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_size     <= c_SZ_WORD;
            r_ext      <= 1'b0;
            r_misalign <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_rdata    <= 32'd0;
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= 32'd0;
                    if (req) begin
                        r_we       <= we;
                        r_addr     <= w_base;
                        r_wdata    <= wdata;
                        r_size     <= w_size;
                        r_ext      <= UnsignedExt_Mem;
                        r_misalign <= w_misalign;
                        r_busy     <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            r_state <= c_WAIT;
                            r_cnt   <= c_WAIT_LOAD;
                        end else begin
                            r_state <= c_RESP;
                            r_ack   <= 1'b1;
                            r_err   <= w_misalign;
                            r_rdata <= w_rdata_next;
                        end
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_RESP;
                        r_ack   <= 1'b1;
                        r_err   <= r_misalign;
                        r_rdata <= w_rdata_next;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= 32'd0;
                    r_busy  <= 1'b0;
                    // The store lands as the response completes.
                    if (r_we && !r_misalign) begin
                        r_mem[r_addr] <= r_wdata[7:0];
                        if (r_size != c_SZ_BYTE) begin
                            r_mem[r_addr + c_OFS1] <= r_wdata[15:8];
                        end
                        if (r_size == c_SZ_WORD) begin
                            r_mem[r_addr + c_OFS2] <= r_wdata[23:16];
                            r_mem[r_addr + c_OFS3] <= r_wdata[31:24];
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= 32'd0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH_BYTES; gi++) begin : g_ram
            assign ram_content[8*gi +: 8] = r_mem[gi];
        end
    endgenerate

    assign ack   = r_ack;
    assign rdata = r_rdata;
    assign err   = r_err;
    assign busy  = r_busy;

endmodule
`default_nettype wire
